// File: rtl/tone_pkg.sv
// Shared types and constants for the tone detector: FSM state encoding, channel-index width
// helper, and direction codes used downstream to map det_ch onto motion commands.
package tone_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StQualify = 2'd1,
        StLocked  = 2'd2,
        StRelease = 2'd3
    } tone_state_e;

    localparam logic [2:0] STOP     = 3'b100;
    localparam logic [2:0] STRAIGHT = 3'b000;
    localparam logic [2:0] LEFT     = 3'b001;
    localparam logic [2:0] RIGHT    = 3'b010;
    localparam logic [2:0] BACK     = 3'b011;

    function automatic int unsigned ch_idx_w(input int unsigned n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/tone_channel_qual.sv
// One tone channel: 2-flop synchroniser, saturating high-time counter and a single-cycle
// qualify strobe when the tone has been high for HOLD_CYCLES synchronised cycles.
module tone_channel_qual #(
    parameter int unsigned HOLD_CYCLES = 12_500_000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tone_i,
    input  logic clear_i,
    output logic tone_sync_o,
    output logic qualify_o
);

    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= tone_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
        end
    end

    // Any low cycle restarts the count; the count sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign tone_sync_o = sync2_q;
    assign qualify_o   = sync2_q && (cnt_q == HoldLast);

endmodule

// File: rtl/tone_detector_n.sv
// N-channel tone detector: qualifies a sustained tone on any channel, locks onto the lowest
// qualifying index, holds it through short dropouts and flags competing tones while locked.
module tone_detector_n
    import tone_pkg::*;
#(
    parameter int unsigned N_CH           = 5,
    parameter int unsigned HOLD_CYCLES    = 12_500_000,
    parameter int unsigned RELEASE_CYCLES = 1_250_000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_CH-1:0]             tone_in,
    input  logic                        clear,
    output logic [ch_idx_w(N_CH)-1:0]   det_ch,
    output logic                        det_valid,
    output logic                        locked,
    output logic [N_CH-1:0]             tone_active,
    output logic                        conflict
);

    localparam int unsigned      IdxW    = ch_idx_w(N_CH);
    localparam logic [CNT_W-1:0] RelLast = CNT_W'(RELEASE_CYCLES - 1);

    logic [N_CH-1:0] tone_sync;
    logic [N_CH-1:0] qualify;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        tone_channel_qual #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .CNT_W       (CNT_W)
        ) u_qual (
            .clk         (clk),
            .rst_n       (rst_n),
            .tone_i      (tone_in[g]),
            .clear_i     (clear),
            .tone_sync_o (tone_sync[g]),
            .qualify_o   (qualify[g])
        );
    end

    tone_state_e      state_q;
    tone_state_e      state_d;
    logic [IdxW-1:0]  det_ch_q;
    logic [IdxW-1:0]  det_ch_d;
    logic             det_valid_q;
    logic             det_valid_d;
    logic             conflict_q;
    logic             conflict_d;
    logic [CNT_W-1:0] rel_cnt_q;
    logic [CNT_W-1:0] rel_cnt_d;

    logic [IdxW-1:0]  win_idx;
    logic [N_CH-1:0]  lock_mask;
    logic             lock_tone;
    logic             other_qual;

    // Scan from the top so the lowest qualifying index is the one left standing.
    always_comb begin
        win_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (qualify[i]) begin
                win_idx = IdxW'(i);
            end
        end
    end

    always_comb begin
        lock_mask = '0;
        for (int i = 0; i < N_CH; i++) begin
            lock_mask[i] = (det_ch_q == IdxW'(i));
        end
    end

    assign lock_tone  = |(tone_sync & lock_mask);
    assign other_qual = |(qualify & ~lock_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            det_ch_q    <= '0;
            det_valid_q <= 1'b0;
            conflict_q  <= 1'b0;
            rel_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            det_ch_q    <= det_ch_d;
            det_valid_q <= det_valid_d;
            conflict_q  <= conflict_d;
            rel_cnt_q   <= rel_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        det_ch_d    = det_ch_q;
        det_valid_d = 1'b0;
        conflict_d  = conflict_q;
        rel_cnt_d   = '0;
        if (clear) begin
            state_d    = StIdle;
            conflict_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|tone_sync) begin
                        state_d = StQualify;
                    end
                end
                StQualify: begin
                    if (|qualify) begin
                        state_d     = StLocked;
                        det_ch_d    = win_idx;
                        det_valid_d = 1'b1;
                    end else if (!(|tone_sync)) begin
                        state_d = StIdle;
                    end
                end
                StLocked: begin
                    if (other_qual) begin
                        conflict_d = 1'b1;
                    end
                    if (!lock_tone) begin
                        state_d = StRelease;
                    end
                end
                StRelease: begin
                    if (other_qual) begin
                        conflict_d = 1'b1;
                    end
                    // A completed release count wins over the tone returning on that same cycle.
                    if (rel_cnt_q == RelLast) begin
                        state_d = StIdle;
                    end else if (lock_tone) begin
                        state_d = StLocked;
                    end else begin
                        rel_cnt_d = rel_cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign det_ch      = det_ch_q;
    assign det_valid   = det_valid_q;
    assign locked      = (state_q == StLocked) || (state_q == StRelease);
    assign tone_active = tone_sync;
    assign conflict    = conflict_q;

endmodule
